// File: rtl/axi_bram_fifo_stream_master.sv
// AXI4-Lite register front end that queues pushed words and replays them on an AXI-Stream master port.
// Latency: a push reaches tvalid two edges later; backpressure: tready stalls the output stage, and a write to a full queue is dropped with SLVERR.
module axi_bram_fifo_stream_master #(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH           = 16
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic                              m00_axis_tvalid,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   m00_axis_tdata,
  output logic                              m00_axis_tlast,
  input  logic                              m00_axis_tready
);
  localparam int DW = C_S00_AXI_DATA_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   fifo_cnt, occupancy;
  logic          enable, last_next;
  logic [DW-1:0] tx_count, rd_mux;
  logic [1:0]    wr_reg, rd_reg;
  logic          wr_hs, rd_hs, full, empty, flush, push, load, beat, cnt_clr;
  logic [3:0]    unused_addr_bits;

  assign unused_addr_bits = {s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign wr_hs   = s00_axi_awready & s00_axi_awvalid & s00_axi_wready & s00_axi_wvalid;
  assign rd_hs   = s00_axi_arready & s00_axi_arvalid;
  assign wr_reg  = s00_axi_awaddr[3:2];
  assign rd_reg  = s00_axi_araddr[3:2];

  // The output-stage word counts towards capacity, so FULL is judged on the combined total.
  assign occupancy = fifo_cnt + (PW+1)'(m00_axis_tvalid);
  assign full      = (occupancy == FULL_CNT);
  assign empty     = (occupancy == '0);

  assign flush   = wr_hs && (wr_reg == 2'd1) && s00_axi_wdata[2];
  assign push    = wr_hs && (wr_reg == 2'd0) && !full;
  assign cnt_clr = wr_hs && (wr_reg == 2'd3);
  assign beat    = m00_axis_tvalid & m00_axis_tready;
  assign load    = enable && (fifo_cnt != '0) && !flush && (!m00_axis_tvalid || m00_axis_tready);

  assign s00_axi_rresp = 2'b00;

  always_ff @(posedge s00_axi_aclk) begin
    if (push) mem[wr_ptr] <= '{last: last_next, data: s00_axi_wdata};
  end

  always_comb begin
    rd_mux = '0;
    case (rd_reg)
      2'd1: rd_mux[1:0] = {last_next, enable};
      2'd2: begin
        rd_mux[0]    = empty;
        rd_mux[1]    = full;
        rd_mux[15:8] = 8'(occupancy);
      end
      2'd3:    rd_mux = tx_count;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_cnt        <= '0;
      enable          <= 1'b0;
      last_next       <= 1'b0;
      tx_count        <= '0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tdata  <= '0;
      m00_axis_tlast  <= 1'b0;
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
      s00_axi_bresp   <= 2'b00;
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rdata   <= '0;
    end else begin
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fifo_cnt <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (load) rd_ptr <= rd_ptr + PW'(1);
        fifo_cnt <= fifo_cnt + (PW+1)'(push) - (PW+1)'(load);
      end

      // A presented word stays put until accepted, regardless of ENABLE or FLUSH.
      if (load) begin
        m00_axis_tvalid <= 1'b1;
        m00_axis_tdata  <= mem[rd_ptr].data;
        m00_axis_tlast  <= mem[rd_ptr].last;
      end else if (beat) begin
        m00_axis_tvalid <= 1'b0;
      end

      if (wr_hs && (wr_reg == 2'd1)) begin
        enable    <= s00_axi_wdata[0];
        last_next <= s00_axi_wdata[1];
      end else if (push) begin
        last_next <= 1'b0;
      end

      if (cnt_clr)   tx_count <= '0;
      else if (beat) tx_count <= tx_count + DW'(1);

      if (!s00_axi_awready && s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid) begin
        s00_axi_awready <= 1'b1;
        s00_axi_wready  <= 1'b1;
      end else begin
        s00_axi_awready <= 1'b0;
        s00_axi_wready  <= 1'b0;
      end

      if (wr_hs) begin
        s00_axi_bvalid <= 1'b1;
        s00_axi_bresp  <= ((wr_reg == 2'd0) && full) ? 2'b10 : 2'b00;
      end else if (s00_axi_bready) begin
        s00_axi_bvalid <= 1'b0;
      end

      s00_axi_arready <= !s00_axi_arready && s00_axi_arvalid && !s00_axi_rvalid;

      if (rd_hs) begin
        s00_axi_rvalid <= 1'b1;
        s00_axi_rdata  <= rd_mux;
      end else if (s00_axi_rready) begin
        s00_axi_rvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axi_bram_fifo_stream_master.sv
// Directed and randomized bench: a queue of expected {last,data} words models the stream; register reads are predicted from that queue.
`timescale 1ns/1ps
module tb_axi_bram_fifo_stream_master;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          tb_ACLK = 1'b0;
  logic          aresetn;
  logic [AW-1:0] s00_axi_awaddr, s00_axi_araddr;
  logic          s00_axi_awvalid, s00_axi_awready, s00_axi_wvalid, s00_axi_wready;
  logic [DW-1:0] s00_axi_wdata, s00_axi_rdata, m00_axis_tdata;
  logic [1:0]    s00_axi_bresp, s00_axi_rresp;
  logic          s00_axi_bvalid, s00_axi_bready, s00_axi_arvalid, s00_axi_arready;
  logic          s00_axi_rvalid, s00_axi_rready;
  logic          m00_axis_tvalid, m00_axis_tlast, m00_axis_tready;

  always #5 tb_ACLK = ~tb_ACLK;

  axi_bram_fifo_stream_master #(
    .C_S00_AXI_DATA_WIDTH(DW), .C_S00_AXI_ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .s00_axi_aclk(tb_ACLK), .s00_axi_aresetn(aresetn),
    .s00_axi_awaddr(s00_axi_awaddr), .s00_axi_awvalid(s00_axi_awvalid), .s00_axi_awready(s00_axi_awready),
    .s00_axi_wdata(s00_axi_wdata), .s00_axi_wvalid(s00_axi_wvalid), .s00_axi_wready(s00_axi_wready),
    .s00_axi_bresp(s00_axi_bresp), .s00_axi_bvalid(s00_axi_bvalid), .s00_axi_bready(s00_axi_bready),
    .s00_axi_araddr(s00_axi_araddr), .s00_axi_arvalid(s00_axi_arvalid), .s00_axi_arready(s00_axi_arready),
    .s00_axi_rdata(s00_axi_rdata), .s00_axi_rresp(s00_axi_rresp), .s00_axi_rvalid(s00_axi_rvalid),
    .s00_axi_rready(s00_axi_rready),
    .m00_axis_tvalid(m00_axis_tvalid), .m00_axis_tdata(m00_axis_tdata), .m00_axis_tlast(m00_axis_tlast),
    .m00_axis_tready(m00_axis_tready)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  logic [32:0] exp_q[$];
  int          exp_tx = 0;
  logic        model_last_next = 1'b0;
  bit          rnd_tready = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] status_of(input int n);
    logic [31:0] s;
    s = 32'(n) << 8;
    if (n == 0) s[0] = 1'b1;
    if (n == DEPTH) s[1] = 1'b1;
    return s;
  endfunction

  // Every stream beat must match the oldest word the model still expects.
  always @(negedge tb_ACLK) begin
    if (aresetn && m00_axis_tvalid && m00_axis_tready) begin
      if (exp_q.size() == 0) check("stream_extra_beat", 64'(m00_axis_tvalid), 64'd0);
      else check("stream_beat", 64'({m00_axis_tlast, m00_axis_tdata}), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge tb_ACLK);
    #1;
    if (rnd_tready) m00_axis_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data, output logic [1:0] resp);
    int k;
    s00_axi_awaddr = addr; s00_axi_wdata = data;
    s00_axi_awvalid = 1'b1; s00_axi_wvalid = 1'b1;
    k = 0;
    while (!s00_axi_awready && k < 50) begin step(); k++; end
    check("aw_accept", 64'(s00_axi_awready), 64'd1);
    step();
    s00_axi_awvalid = 1'b0; s00_axi_wvalid = 1'b0;
    k = 0;
    while (!s00_axi_bvalid && k < 50) begin step(); k++; end
    check("b_arrive", 64'(s00_axi_bvalid), 64'd1);
    resp = s00_axi_bresp;
    s00_axi_bready = 1'b1;
    step();
    s00_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] data);
    int k;
    s00_axi_araddr = addr; s00_axi_arvalid = 1'b1;
    k = 0;
    while (!s00_axi_arready && k < 50) begin step(); k++; end
    check("ar_accept", 64'(s00_axi_arready), 64'd1);
    step();
    s00_axi_arvalid = 1'b0;
    k = 0;
    while (!s00_axi_rvalid && k < 50) begin step(); k++; end
    check("r_arrive", 64'(s00_axi_rvalid), 64'd1);
    data = s00_axi_rdata;
    s00_axi_rready = 1'b1;
    step();
    s00_axi_rready = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [AW-1:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(addr, d);
    check(tag, 64'(d), 64'(exp));
  endtask

  task automatic write_ctrl(input logic [31:0] d);
    logic [1:0] r;
    model_last_next = d[1];
    axi_write(4'h4, d, r);
    check("ctrl_bresp", 64'(r), 64'd0);
  endtask

  task automatic push_word(input logic [31:0] d);
    logic [1:0] r, er;
    er = (exp_q.size() >= DEPTH) ? 2'b10 : 2'b00;
    if (er == 2'b00) begin
      exp_q.push_back({model_last_next, d});
      exp_tx++;
      model_last_next = 1'b0;
    end
    axi_write(4'h0, d, r);
    check("tx_bresp", 64'(r), 64'(er));
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin step(); k++; end
    check("drain_remaining", 64'(exp_q.size()), 64'd0);
    repeat (4) step();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_axi"}, 64'({s00_axi_awready, s00_axi_wready, s00_axi_bvalid, s00_axi_bresp,
                              s00_axi_arready, s00_axi_rvalid, s00_axi_rdata, s00_axi_rresp}), 64'd0);
    check({tag, "_axis"}, 64'({m00_axis_tvalid, m00_axis_tdata, m00_axis_tlast}), 64'd0);
  endtask

  initial begin
    logic [1:0]  r;
    logic [31:0] hold_x;
    int          k;
    logic [31:0] seq4[4];
    seq4[0] = 32'h0101FFFF; seq4[1] = 32'hABCD0001; seq4[2] = 32'hDEAD0011; seq4[3] = 32'hBEEF0011;

    aresetn = 1'b0;
    s00_axi_awaddr = '0; s00_axi_awvalid = 1'b0; s00_axi_wdata = '0; s00_axi_wvalid = 1'b0;
    s00_axi_bready = 1'b0; s00_axi_araddr = '0; s00_axi_arvalid = 1'b0; s00_axi_rready = 1'b0;
    m00_axis_tready = 1'b0;
    repeat (3) @(posedge tb_ACLK);
    #1;
    check_outputs_zero("reset");

    // A write presented right at deassertion must not complete on the first edge.
    aresetn = 1'b1;
    s00_axi_awaddr = 4'h4; s00_axi_wdata = 32'h0; s00_axi_awvalid = 1'b1; s00_axi_wvalid = 1'b1;
    step();
    check("first_edge_no_bvalid", 64'(s00_axi_bvalid), 64'd0);
    k = 0;
    while (!s00_axi_bvalid && k < 20) begin step(); k++; end
    check("post_reset_write_done", 64'(s00_axi_bvalid), 64'd1);
    s00_axi_awvalid = 1'b0; s00_axi_wvalid = 1'b0; s00_axi_bready = 1'b1;
    step();
    s00_axi_bready = 1'b0;
    read_check("status_after_reset", 4'h8, status_of(0));

    // Four words in order with the stream enabled.
    m00_axis_tready = 1'b1;
    write_ctrl(32'h1);
    for (int i = 0; i < 4; i++) push_word(seq4[i]);
    drain();
    read_check("txcount_4", 4'hC, 32'(exp_tx));
    read_check("status_idle", 4'h8, status_of(0));
    read_check("txdata_reads_0", 4'h0, 32'h0);

    // LAST_NEXT tags exactly one word and then clears.
    write_ctrl(32'h3);
    push_word(32'hAAAA_0001);
    push_word(32'hBBBB_0002);
    read_check("ctrl_last_cleared", 4'h4, 32'h1);
    drain();

    // Fill to capacity with the stream disabled, then overflow by one.
    write_ctrl(32'h0);
    for (int i = 0; i < DEPTH + 1; i++) push_word($urandom);
    read_check("status_full", 4'h8, status_of(exp_q.size()));
    write_ctrl(32'h1);
    drain();
    read_check("txcount_after_full", 4'hC, 32'(exp_tx));
    axi_write(4'hC, $urandom, r);
    check("clear_bresp", 64'(r), 64'd0);
    exp_tx = 0;
    read_check("txcount_cleared", 4'hC, 32'(exp_tx));
    axi_write(4'h8, 32'hFFFF_FFFF, r);
    check("status_write_ok", 64'(r), 64'd0);
    read_check("status_write_ignored", 4'h8, status_of(0));

    // FLUSH with a word presented under backpressure keeps only that word.
    m00_axis_tready = 1'b0;
    push_word(32'hC0DE_0001);
    push_word(32'hC0DE_0002);
    push_word(32'hC0DE_0003);
    repeat (3) step();
    hold_x = exp_q[0][31:0];
    check("presented_tvalid", 64'(m00_axis_tvalid), 64'd1);
    check("presented_tdata", 64'(m00_axis_tdata), 64'(hold_x));
    write_ctrl(32'h5);
    while (exp_q.size() > 1) begin void'(exp_q.pop_back()); exp_tx--; end
    repeat (3) step();
    check("flush_hold_tvalid", 64'(m00_axis_tvalid), 64'd1);
    check("flush_hold_tdata", 64'(m00_axis_tdata), 64'(hold_x));
    read_check("status_one_left", 4'h8, status_of(exp_q.size()));
    m00_axis_tready = 1'b1;
    drain();
    read_check("status_after_flush", 4'h8, status_of(0));
    read_check("txcount_after_flush", 4'hC, 32'(exp_tx));

    // Randomized pushes against random tready.
    rnd_tready = 1'b1;
    write_ctrl(32'h1);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) write_ctrl(32'h3);
      push_word($urandom);
      repeat ($urandom_range(0, 3)) step();
    end
    rnd_tready = 1'b0;
    m00_axis_tready = 1'b1;
    drain();
    read_check("txcount_random", 4'hC, 32'(exp_tx));
    read_check("status_random", 4'h8, status_of(0));

    // Held write response blocks a second write.
    s00_axi_awaddr = 4'h4; s00_axi_wdata = 32'h1; s00_axi_awvalid = 1'b1; s00_axi_wvalid = 1'b1;
    k = 0;
    while (!s00_axi_bvalid && k < 50) begin step(); k++; end
    check("hold_b_arrive", 64'(s00_axi_bvalid), 64'd1);
    s00_axi_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_bvalid", 64'(s00_axi_bvalid), 64'd1);
      check("hold_bresp", 64'(s00_axi_bresp), 64'd0);
      check("hold_no_awready", 64'(s00_axi_awready), 64'd0);
    end
    s00_axi_awvalid = 1'b0; s00_axi_wvalid = 1'b0; s00_axi_bready = 1'b1;
    step();
    s00_axi_bready = 1'b0;

    // Held read response stays stable while a new read address is offered.
    s00_axi_araddr = 4'h4; s00_axi_arvalid = 1'b1;
    k = 0;
    while (!s00_axi_rvalid && k < 50) begin step(); k++; end
    check("hold_r_arrive", 64'(s00_axi_rvalid), 64'd1);
    s00_axi_araddr = 4'h8;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_rvalid", 64'(s00_axi_rvalid), 64'd1);
      check("hold_rdata_ctrl", 64'(s00_axi_rdata), 64'd1);
      check("hold_no_arready", 64'(s00_axi_arready), 64'd0);
    end
    s00_axi_arvalid = 1'b0; s00_axi_rready = 1'b1;
    step();
    s00_axi_rready = 1'b0;

    // Reset in the middle of a stalled stream.
    m00_axis_tready = 1'b0;
    write_ctrl(32'h0);
    for (int i = 0; i < 5; i++) push_word($urandom);
    write_ctrl(32'h1);
    repeat (3) step();
    check("pre_reset_tvalid", 64'(m00_axis_tvalid), 64'd1);
    aresetn = 1'b0;
    #1;
    check_outputs_zero("midreset");
    exp_q.delete();
    exp_tx = 0;
    model_last_next = 1'b0;
    repeat (2) step();
    aresetn = 1'b1;
    repeat (2) step();
    read_check("status_after_midreset", 4'h8, status_of(0));
    read_check("ctrl_after_midreset", 4'h4, 32'h0);
    read_check("txcount_after_midreset", 4'hC, 32'(exp_tx));
    check("tvalid_after_midreset", 64'(m00_axis_tvalid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
